accel_tilt_led: RTL and testbench
=================================

Name: accel_tilt_led

Overview:
- Sits directly downstream of the accelerometer SPI reader.
- Consumes signed X-axis acceleration samples through a valid/ready handshake and smooths them with a power-of-two moving average.
- Maps the smoothed tilt to a single lit LED on the 10-LED bar, with hysteresis so the lit LED does not flicker at boundaries.
- Blinks the lit LED when the tilt is beyond full scale.
- Drives the board LED export directly, replacing the software LED path.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- AVG_LOG2, 3: log2 of the averaging window (window = 8 samples).
- LED_N, 10: number of LEDs in the bar.
- FS_LOG2, 8: full scale is ±2^FS_LOG2 counts across the bar.
- HYST, 8: hysteresis in counts.
- BLINK_DIV, 25000000: clock cycles per blink half-period.

Ports:
- clk_clk, in, 1: system clock.
- reset_reset, in, 1: asynchronous, active-high reset.
- sample_valid, in, 1: upstream sample available.
- sample_ready, out, 1: block can accept a sample.
- sample_data, in, DATA_W: signed X-axis sample.
- avg_data, out, DATA_W: latest moving average, signed.
- avg_valid, out, 1: one-cycle pulse when avg_data and the LED bar update.
- primed, out, 1: window has been filled since reset.
- led_external_connection_export, out, LED_N: LED bar, one-hot.

Behaviour:
- Reset values (asynchronous, active-high):
  - FSM in IDLE; sample_ready=1; avg_data=0; avg_valid=0; primed=0.
  - cur_idx=LED_N/2 (5), so led_external_connection_export=10'h020.
  - All window buffer entries, running sum, write pointer, fill count and blink counter cleared to 0; blink phase = on.
- Handshake:
  - A beat occurs when sample_valid and sample_ready are both high at a rising edge.
  - Upstream must hold sample_data stable while valid is high and ready is low.
- FSM states IDLE -> ACCUM -> MAP -> IDLE:
  - IDLE: sample_ready=1. On a beat, capture sample_data and go to ACCUM.
  - ACCUM: sample_ready=0.
    - sum <= sum + sample - buf[wr_ptr]; buf[wr_ptr] <= sample.
    - wr_ptr increments and wraps modulo 2^AVG_LOG2.
    - Fill count increments, saturating at 2^AVG_LOG2.
  - MAP: sample_ready=0.
    - avg = sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf), registered into avg_data.
    - avg_valid pulses for this one cycle; cur_idx updates; primed <= (fill count == 2^AVG_LOG2).
- Latency and throughput:
  - Beat at edge E0; avg_data, avg_valid and the LED bar change at E2; sample_ready is high again after E2.
  - Maximum throughput is 1 sample per 3 cycles.
- Widths:
  - Running sum is DATA_W+AVG_LOG2 bits signed and can never overflow.
  - Until primed, zero-initialised buffer entries are included, so the average is biased toward 0. This is intended.
- Index mapping:
  - c = clamp(avg, -2^FS_LOG2, 2^FS_LOG2 - 1).
  - idx = ((c + 2^FS_LOG2) * LED_N) >> (FS_LOG2+1), giving a range of 0..LED_N-1.
  - With defaults: avg=0 -> 5, avg=-256 -> 0, avg>=255 -> 9, and idx 6 starts at avg=52.
- Hysteresis:
  - idx_lo = idx(avg-HYST) and idx_hi = idx(avg+HYST), both computed through the clamp.
  - If idx_lo <= cur_idx <= idx_hi, cur_idx is kept; otherwise cur_idx <= idx(avg).
- LED output:
  - Normally one-hot(cur_idx).
  - Saturation flag = avg < -2^FS_LOG2 or avg > 2^FS_LOG2 - 1, registered in MAP.
  - While saturated, the output is one-hot(cur_idx) ANDed with blink phase, which toggles every BLINK_DIV cycles from a free-running counter.
  - When saturation clears, the LED is solid on the next update.
- sample_valid while not in IDLE has no effect.
- Reset mid-operation: the in-flight sample is dropped and the next beat is treated as the first sample after reset.

Decomposition:
- Package accel_pkg holds:
  - DATA_W and LED_N defaults.
  - FSM state enum (IDLE, ACCUM, MAP).
  - A function for the clamp/index mapping.
- Sub-module moving_avg holds the circular buffer, running sum, write pointer and fill count, with inputs load/sample and outputs sum/full.
- The FSM, hysteresis, blink logic and LED encoding stay in the top module.

Test Plan:
1. Reset asserted, then released -> led=10'h020, sample_ready=1, avg_valid=0, primed=0, avg_data=0.
2. Sample_valid held high with data +128 for 8 beats:
   - sample_ready pattern is 1,0,0 repeating.
   - avg_data steps 16,32,…,128.
   - primed rises with the 8th avg_valid.
   - led=10'h080 (idx 7) after the 8th update.
3. Primed at avg 0 (idx 5):
   - Window filled with 55 -> avg 55, lo=47 maps to idx 5, led stays 10'h020.
   - Window filled with 61 -> lo=53 maps to idx 6, led becomes 10'h040.
4. With BLINK_DIV=4, window filled with +1000 -> idx 9; led alternates 10'h200 and 10'h000 every 4 cycles; a subsequent avg of 200 gives solid 10'h200.
5. Negative values:
   - Window filled with -256 -> led=10'h001.
   - Window filled with -20 -> avg_data=-20 (sum -160 >>> 3).
   - Single -1 after reset -> avg_data=-1 (rounds toward -inf).
6. Reset asserted during ACCUM -> all outputs return to reset values immediately. The next beat of 80 gives avg_data=10 and primed=0.

Source files
------------

// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared defaults, FSM state encoding and the tilt-to-LED
//                index mapping used by the accelerometer LED bar block.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LED_N  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_MAP   = 2'd2
    } state_t;

    // Clamp v to [-2^fs_log2, 2^fs_log2-1], then scale the shifted value
    // 0..2^(fs_log2+1)-1 onto 0..led_n-1.
    function automatic logic [31:0] map_idx(input logic signed [31:0] v,
                                            input int fs_log2,
                                            input int led_n);
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        logic signed [31:0] c;
        logic signed [31:0] prod;
        lo = -(32'sd1 <<< fs_log2);
        hi = (32'sd1 <<< fs_log2) - 32'sd1;
        if (v < lo) begin
            c = lo;
        end else if (v > hi) begin
            c = hi;
        end else begin
            c = v;
        end
        prod = (c - lo) * led_n;
        return prod >>> (fs_log2 + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/moving_avg.sv
`default_nettype none
// ============================================================================
//  Module      : moving_avg
//  Description : Circular window of 2^AVG_LOG2 signed samples with a running
//                sum. Each load pulse replaces the oldest entry with sample.
//  Ports       : clk, rst (async, active-high)
//                load   - commit sample into the window this cycle
//                sample - signed sample to commit
//                sum    - running sum of the window (never overflows)
//                full   - 2^AVG_LOG2 samples committed since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module moving_avg
    import accel_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AVG_LOG2 = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic signed [DATA_W-1:0]         sample,
    output logic signed [DATA_W+AVG_LOG2-1:0] sum,
    output logic                             full
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(DEPTH);

    logic signed [DATA_W-1:0] win_q [DEPTH];
    logic signed [DATA_W-1:0] win_d [DEPTH];
    logic [AVG_LOG2-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]        fill_q, fill_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] oldest_w;

    assign oldest_w = win_q[wr_ptr_q];

    always_comb begin
        win_d    = win_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        if (load) begin
            win_d[wr_ptr_q] = sample;
            sum_d = sum_q
                  + {{AVG_LOG2{sample[DATA_W-1]}}, sample}
                  - {{AVG_LOG2{oldest_w[DATA_W-1]}}, oldest_w};
            wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + (AVG_LOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
        end else begin
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
        end
    end

    assign sum  = sum_q;
    assign full = (fill_q == FILL_MAX);

endmodule
`default_nettype wire

// File: rtl/accel_tilt_led.sv
`default_nettype none
// ============================================================================
//  Module      : accel_tilt_led
//  Description : Smooths signed X-axis accelerometer samples with a moving
//                average and lights one LED of a bar according to tilt, with
//                hysteresis, blinking the LED when tilt exceeds full scale.
//  Ports       : clk_clk, reset_reset (async, active-high)
//                sample_valid/sample_ready/sample_data - input handshake
//                avg_data  - latest moving average (signed)
//                avg_valid - one-cycle pulse on each average/LED update
//                primed    - window filled since reset
//                led_external_connection_export - one-hot LED bar
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_tilt_led
    import accel_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int AVG_LOG2  = 3,
    parameter int LED_N     = DEF_LED_N,
    parameter int FS_LOG2   = 8,
    parameter int HYST      = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    output logic              primed,
    output logic [LED_N-1:0]  led_external_connection_export
);

    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int IDX_W  = (LED_N > 1) ? $clog2(LED_N) : 1;
    localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int FS_MIN = -(1 << FS_LOG2);
    localparam int FS_MAX = (1 << FS_LOG2) - 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_RESET  = IDX_W'(LED_N / 2);

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic signed [DATA_W-1:0] avg_q, avg_d;
    logic                     avg_valid_q, avg_valid_d;
    logic                     primed_q, primed_d;
    logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
    logic                     sat_q, sat_d;
    logic [CNT_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                     blink_on_q, blink_on_d;

    logic                     load_w;
    logic signed [SUM_W-1:0]  sum_w;
    logic                     full_w;
    logic signed [DATA_W-1:0] avg_w;
    logic signed [31:0]       avg_ext_w;
    logic [IDX_W-1:0]         idx_w, idx_lo_w, idx_hi_w;
    logic                     sat_w;
    logic [LED_N-1:0]         onehot_w;

    moving_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_moving_avg (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .load   (load_w),
        .sample (sample_q),
        .sum    (sum_w),
        .full   (full_w)
    );

    assign load_w = (state_q == ST_ACCUM);

    // Arithmetic shift: average rounds toward -inf.
    assign avg_w     = DATA_W'(sum_w >>> AVG_LOG2);
    assign avg_ext_w = 32'(avg_w);

    // Hysteresis window: indices reachable from avg +/- HYST, both clamped.
    assign idx_w    = IDX_W'(map_idx(avg_ext_w, FS_LOG2, LED_N));
    assign idx_lo_w = IDX_W'(map_idx(avg_ext_w - HYST, FS_LOG2, LED_N));
    assign idx_hi_w = IDX_W'(map_idx(avg_ext_w + HYST, FS_LOG2, LED_N));
    assign sat_w    = (avg_ext_w < FS_MIN) || (avg_ext_w > FS_MAX);

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        primed_d    = primed_q;
        cur_idx_d   = cur_idx_q;
        sat_d       = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_data;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                state_d = ST_MAP;
            end
            ST_MAP: begin
                avg_d       = avg_w;
                avg_valid_d = 1'b1;
                primed_d    = full_w;
                sat_d       = sat_w;
                if (!((cur_idx_q >= idx_lo_w) && (cur_idx_q <= idx_hi_w))) begin
                    cur_idx_d = idx_w;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Free-running blink timebase; phase holds for BLINK_DIV cycles.
    always_comb begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            cur_idx_q   <= IDX_RESET;
            sat_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            primed_q    <= primed_d;
            cur_idx_q   <= cur_idx_d;
            sat_q       <= sat_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign onehot_w = {{(LED_N-1){1'b0}}, 1'b1} << cur_idx_q;

    assign sample_ready = (state_q == ST_IDLE);
    assign avg_data     = avg_q;
    assign avg_valid    = avg_valid_q;
    assign primed       = primed_q;
    assign led_external_connection_export = onehot_w & {LED_N{blink_on_q | ~sat_q}};

endmodule
`default_nettype wire

// File: tb/tb_accel_tilt_led.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_tilt_led
//  Description : Directed self-checking bench for accel_tilt_led.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_tilt_led;

    logic               clk;
    logic               rst;
    logic               sample_valid;
    logic               sample_ready;
    logic [15:0]        sample_data;
    logic signed [15:0] avg_data;
    logic               avg_valid;
    logic               primed;
    logic [9:0]         led;

    int n_checks;
    int n_fail;

    accel_tilt_led #(
        .DATA_W    (16),
        .AVG_LOG2  (3),
        .LED_N     (10),
        .FS_LOG2   (8),
        .HYST      (8),
        .BLINK_DIV (4)
    ) dut (
        .clk_clk                        (clk),
        .reset_reset                    (rst),
        .sample_valid                   (sample_valid),
        .sample_ready                   (sample_ready),
        .sample_data                    (sample_data),
        .avg_data                       (avg_data),
        .avg_valid                      (avg_valid),
        .primed                         (primed),
        .led_external_connection_export (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)",
                     tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One handshake beat, then wait (bounded) for the resulting update pulse.
    task automatic send(input logic signed [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
        while (!sample_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", sample_ready, 1);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!avg_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("avg_valid_wait", avg_valid, 1);
    endtask

    task automatic fill(input logic signed [15:0] d);
        for (int i = 0; i < 8; i++) begin
            send(d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] s [16];
        int t;

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;

        // 1. Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", led, 10'h020);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_led_rel", led, 10'h020);
        chk("rst_ready", sample_ready, 1);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_primed", primed, 0);
        chk("rst_avg_data", avg_data, 0);

        // 2. Valid held high with +128 for 8 beats
        sample_valid = 1'b1;
        sample_data  = 16'd128;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 22) sample_valid = 1'b0;
            chk("t2_ready", sample_ready, (i % 3) == 0);
            chk("t2_avg_valid", avg_valid, ((i % 3) == 0) && (i > 0));
            if ((i % 3) == 0 && i > 0) begin
                chk("t2_avg_data", avg_data, 16 * (i / 3));
                chk("t2_primed", primed, i == 24);
            end
        end
        chk("t2_led", led, 10'h080);

        // 3. Hysteresis around the idx 5/6 boundary
        fill(16'sd0);
        chk("t3_avg0", avg_data, 0);
        chk("t3_led0", led, 10'h020);
        fill(16'sd55);
        chk("t3_avg55", avg_data, 55);
        chk("t3_led55", led, 10'h020);
        fill(16'sd61);
        chk("t3_avg61", avg_data, 61);
        chk("t3_led61", led, 10'h040);

        // 4. Saturation blink, then back to solid
        fill(16'sd1000);
        chk("t4_avg1000", avg_data, 1000);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s[k] = led;
        end
        for (int k = 0; k < 16; k++) begin
            chk("t4_blink_level", (s[k] == 10'h200) || (s[k] == 10'h000), 1);
        end
        t = -1;
        for (int k = 1; k < 16; k++) begin
            if (t < 0 && s[k] != s[k-1]) t = k;
        end
        chk("t4_blink_first_toggle", (t >= 1) && (t <= 4), 1);
        if (t >= 1) begin
            for (int k = t + 1; k < 16; k++) begin
                chk("t4_blink_period", s[k] != s[k-1], ((k - t) % 4) == 0);
            end
        end
        fill(16'sd200);
        chk("t4_avg200", avg_data, 200);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_solid", led, 10'h200);
        end

        // 5. Negative values
        fill(-16'sd256);
        chk("t5_avg_m256", avg_data, -256);
        chk("t5_led_m256", led, 10'h001);
        fill(-16'sd20);
        chk("t5_avg_m20", avg_data, -20);
        do_reset();
        send(-16'sd1);
        chk("t5_avg_m1", avg_data, -1);
        chk("t5_primed_m1", primed, 0);
        chk("t5_led_m1", led, 10'h020);

        // 6. Reset while in ACCUM
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 16'd40;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        chk("t6_accum_ready", sample_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ready", sample_ready, 1);
        chk("t6_rst_avg_valid", avg_valid, 0);
        chk("t6_rst_avg_data", avg_data, 0);
        chk("t6_rst_primed", primed, 0);
        chk("t6_rst_led", led, 10'h020);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(16'sd80);
        chk("t6_avg80", avg_data, 10);
        chk("t6_primed80", primed, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
